// File: rtl/div_restoring_32_pkg.sv
// Shared widths, iteration count and FSM encoding for the restoring divider.
//   DATA_WIDTH / DATA_INDEX_LIMIT : operand width (32) and its top bit index (31)
//   DIV_ITER_COUNT                : quotient bits produced, one per ITER cycle
//   div_state_t                   : 2-bit FSM encoding (IDLE, ITER, FIX, DONE)
package div_restoring_32_pkg;

  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned DATA_INDEX_LIMIT = DATA_WIDTH - 1;
  localparam int unsigned DIV_ITER_COUNT   = 32;
  localparam int unsigned CNT_WIDTH        = 5;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_ITER = 2'd1,
    DIV_ST_FIX  = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_restoring_32_rc_add_sub.sv
// 32-bit ripple-carry adder/subtractor (RC_ADD_SUB_32).
//   a, b  : operands
//   sna   : 0 = a + b, 1 = a - b (b inverted, carry-in 1)
//   sum_c : combinational result
//   co_c  : carry out; with sna=1 it is 1 when no borrow occurred (a >= b)
module div_restoring_32_rc_add_sub
  import div_restoring_32_pkg::*;
(
  input  logic [DATA_INDEX_LIMIT:0] a,
  input  logic [DATA_INDEX_LIMIT:0] b,
  input  logic                      sna,
  output logic [DATA_INDEX_LIMIT:0] sum_c,
  output logic                      co_c
);

  logic carry;
  logic bx;

  // One full adder per bit, carry rippling from bit 0 upward.
  always_comb begin
    carry = sna;
    bx    = 1'b0;
    sum_c = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      bx       = b[i] ^ sna;
      sum_c[i] = a[i] ^ bx ^ carry;
      carry    = (a[i] & bx) | (a[i] & carry) | (bx & carry);
    end
    co_c = carry;
  end

endmodule

// File: rtl/div_restoring_32.sv
// Sequential 32-bit restoring divider, one quotient bit per clock.
// Configuration macro: DIV_SIGNED_EN (two's-complement operands, adds FIX state).
//   CLK   : rising-edge clock
//   RST   : synchronous active-high reset
//   START : request, accepted in IDLE
//   A, B  : dividend / divisor, captured on the accepting edge
//   Q, R  : quotient / remainder, held until the next result
//   BUSY  : operation in progress
//   DONE  : one-cycle pulse when Q/R become valid
//   DBZ   : divide-by-zero flag, valid with DONE, cleared on next accepted START
module div_restoring_32
  import div_restoring_32_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [DATA_INDEX_LIMIT:0] A,
  input  logic [DATA_INDEX_LIMIT:0] B,
  output logic [DATA_INDEX_LIMIT:0] Q,
  output logic [DATA_INDEX_LIMIT:0] R,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      DBZ
);

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DIV_ITER_COUNT - 1);

  div_state_t                state;
  logic [DATA_INDEX_LIMIT:0] rem_q;
  logic [DATA_INDEX_LIMIT:0] quo_q;
  logic [DATA_INDEX_LIMIT:0] div_q;
  logic [CNT_WIDTH-1:0]      cnt_q;

  logic [DATA_INDEX_LIMIT:0] shrem_c;
  logic                      take_c;
  logic [DATA_INDEX_LIMIT:0] add_a_c;
  logic [DATA_INDEX_LIMIT:0] add_b_c;
  logic [DATA_INDEX_LIMIT:0] add_s_c;
  logic                      add_co_c;

`ifdef DIV_SIGNED_EN
  logic                      sa_q;
  logic                      sb_q;
  logic [DATA_INDEX_LIMIT:0] neg_in_c;
  logic [DATA_INDEX_LIMIT:0] neg_s_c;
  logic                      neg_co_c;
  logic                      unused_neg_co;

  // Carry-out of a pure 0 - x negation carries no information.
  assign unused_neg_co = neg_co_c;
`endif

  // Trial subtraction; the bit shifted out of rem makes it a 33-bit compare.
  // In the signed build the otherwise idle trial adder also negates B / rem.
  always_comb begin
    shrem_c = {rem_q[DATA_INDEX_LIMIT-1:0], quo_q[DATA_INDEX_LIMIT]};
    take_c  = rem_q[DATA_INDEX_LIMIT] | add_co_c;
    add_a_c = shrem_c;
    add_b_c = div_q;
`ifdef DIV_SIGNED_EN
    neg_in_c = quo_q;
    if (state == DIV_ST_IDLE) begin
      add_a_c  = '0;
      add_b_c  = B;
      neg_in_c = A;
    end else if (state == DIV_ST_FIX) begin
      add_a_c = '0;
      add_b_c = rem_q;
    end
`endif
  end

  div_restoring_32_rc_add_sub u_trial (
    .a     (add_a_c),
    .b     (add_b_c),
    .sna   (1'b1),
    .sum_c (add_s_c),
    .co_c  (add_co_c)
  );

`ifdef DIV_SIGNED_EN
  div_restoring_32_rc_add_sub u_neg (
    .a     ('0),
    .b     (neg_in_c),
    .sna   (1'b1),
    .sum_c (neg_s_c),
    .co_c  (neg_co_c)
  );
`endif

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= DIV_ST_IDLE;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      Q     <= '0;
      R     <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      DBZ   <= 1'b0;
`ifdef DIV_SIGNED_EN
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
`endif
    end else begin
      case (state)
        DIV_ST_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            BUSY  <= 1'b1;
            DBZ   <= (B == '0);
            cnt_q <= '0;
            if (B == '0) begin
              // Divide-by-zero result is staged here and published in DONE.
              quo_q <= '1;
              rem_q <= A;
              state <= DIV_ST_DONE;
            end else begin
              rem_q <= '0;
`ifdef DIV_SIGNED_EN
              quo_q <= A[DATA_INDEX_LIMIT] ? neg_s_c : A;
              div_q <= B[DATA_INDEX_LIMIT] ? add_s_c : B;
              sa_q  <= A[DATA_INDEX_LIMIT];
              sb_q  <= B[DATA_INDEX_LIMIT];
`else
              quo_q <= A;
              div_q <= B;
`endif
              state <= DIV_ST_ITER;
            end
          end
        end

        DIV_ST_ITER: begin
          rem_q <= take_c ? add_s_c : shrem_c;
          quo_q <= {quo_q[DATA_INDEX_LIMIT-1:0], take_c};
          cnt_q <= cnt_q + CNT_WIDTH'(1);
          if (cnt_q == LAST_ITER) begin
`ifdef DIV_SIGNED_EN
            state <= DIV_ST_FIX;
`else
            state <= DIV_ST_DONE;
`endif
          end
        end

`ifdef DIV_SIGNED_EN
        DIV_ST_FIX: begin
          if (sa_q ^ sb_q) quo_q <= neg_s_c;
          if (sa_q)        rem_q <= add_s_c;
          state <= DIV_ST_DONE;
        end
`endif

        DIV_ST_DONE: begin
          Q     <= quo_q;
          R     <= rem_q;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= DIV_ST_IDLE;
        end

        default: state <= DIV_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_restoring_32.sv
module tb_div_restoring_32;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 34;
  localparam int NV  = 6;
`else
  localparam int LAT = 33;
  localparam int NV  = 10;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Q;
  logic [31:0] R;
  logic        BUSY;
  logic        DONE;
  logic        DBZ;

  int n_cmp;
  int n_err;

  vec_t vecs[NV];

  div_restoring_32 dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .DBZ   (DBZ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a START pulse sampled by the next rising edge (edge 0).
  task automatic start_pulse(input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    START = 1'b1;
    A     = a;
    B     = b;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  // Wait (bounded) for DONE; report edges since acceptance and BUSY-high cycles.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = BUSY ? 1 : 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) begin
        lat = i;
        break;
      end
      if (BUSY) busy_cnt++;
    end
  endtask

  initial begin
    int lat;
    int bc;
    int n_done;
    int done_k;
    logic [31:0] q_s;
    logic [31:0] r_s;

    n_cmp = 0;
    n_err = 0;

`ifdef DIV_SIGNED_EN
    vecs[0] = '{32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,        1'b0};
    vecs[2] = '{32'd100,       32'd7,        32'd14,        32'd2,        1'b0};
    vecs[3] = '{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0};
    vecs[4] = '{32'h1234,      32'h0,        32'hFFFF_FFFF, 32'h1234,     1'b1};
    vecs[5] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0};
`else
    vecs[0] = '{32'd100,       32'd7,        32'd14,        32'd2,        1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         32'h7FFF_FFFE, 1'b0};
    vecs[2] = '{32'h1234,      32'h0,        32'hFFFF_FFFF, 32'h1234,     1'b1};
    vecs[3] = '{32'd0,         32'd5,        32'd0,         32'd0,        1'b0};
    vecs[4] = '{32'd5,         32'd10,       32'd0,         32'd5,        1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,        1'b0};
    vecs[7] = '{32'd1000000,   32'd1000,     32'd1000,      32'd0,        1'b0};
    vecs[8] = '{32'hDEAD_BEEF, 32'h10,       32'h0DEA_DBEE, 32'hF,        1'b0};
    vecs[9] = '{32'h8000_0000, 32'd3,        32'h2AAA_AAAA, 32'd2,        1'b0};
`endif

    RST   = 1'b1;
    START = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    chk("reset_q",    Q,            32'h0);
    chk("reset_r",    R,            32'h0);
    chk("reset_busy", 32'(BUSY),    32'h0);
    chk("reset_done", 32'(DONE),    32'h0);
    chk("reset_dbz",  32'(DBZ),     32'h0);

    // Table-driven vectors.
    for (int v = 0; v < NV; v++) begin
      start_pulse(vecs[v].a, vecs[v].b);
      chk("busy_after_accept", 32'(BUSY), 32'h1);
      wait_done(lat, bc);
      chk("latency",    32'(lat),    vecs[v].dbz ? 32'd1 : 32'(LAT));
      chk("busy_cycles", 32'(bc),    vecs[v].dbz ? 32'd1 : 32'(LAT));
      chk("q",          Q,           vecs[v].q);
      chk("r",          R,           vecs[v].r);
      chk("dbz",        32'(DBZ),    32'(vecs[v].dbz));
      chk("busy_at_done", 32'(BUSY), 32'h0);
      @(posedge CLK);
      #1;
      chk("done_pulse_end", 32'(DONE), 32'h0);
      chk("q_held",     Q,           vecs[v].q);
    end

    // DBZ clears on the next accepted START.
    start_pulse(32'h1234, 32'h0);
    wait_done(lat, bc);
    chk("dbz_set", 32'(DBZ), 32'h1);
    @(posedge CLK);
    start_pulse(32'd9, 32'd3);
    chk("dbz_cleared", 32'(DBZ), 32'h0);
    wait_done(lat, bc);
    chk("after_dbz_q", Q, 32'd3);
    chk("after_dbz_r", R, 32'd0);

    // Extra STARTs during an operation are ignored.
    @(posedge CLK);
    start_pulse(32'd100, 32'd7);
    n_done = 0;
    done_k = -1;
    q_s    = '0;
    r_s    = '0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge CLK);
      START = (k == 5 || k == 20);
      A     = 32'd1;
      B     = 32'd1;
      @(posedge CLK);
      #1;
      if (DONE) begin
        n_done++;
        done_k = k;
        q_s    = Q;
        r_s    = R;
      end
    end
    START = 1'b0;
    chk("ignored_start_done_count", 32'(n_done), 32'd1);
    chk("ignored_start_latency",    32'(done_k), 32'(LAT));
    chk("ignored_start_q",          q_s,         32'd14);
    chk("ignored_start_r",          r_s,         32'd2);

    // Synchronous reset mid-operation, then a fresh operation.
    start_pulse(32'd100, 32'd7);
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("midrst_q",    Q,          32'h0);
    chk("midrst_r",    R,          32'h0);
    chk("midrst_busy", 32'(BUSY),  32'h0);
    chk("midrst_done", 32'(DONE),  32'h0);
    chk("midrst_dbz",  32'(DBZ),   32'h0);
    @(negedge CLK);
    RST = 1'b0;
    start_pulse(32'd55, 32'd5);
    wait_done(lat, bc);
    chk("postrst_latency", 32'(lat), 32'(LAT));
    chk("postrst_q",       Q,        32'd11);
    chk("postrst_r",       R,        32'd0);

    // Back-to-back: START sampled on the edge ending the DONE cycle.
    @(posedge CLK);
    start_pulse(32'd20, 32'd6);
    wait_done(lat, bc);
    chk("b2b_first_q", Q, 32'd3);
    chk("b2b_first_r", R, 32'd2);
    start_pulse(32'd40, 32'd6);
    chk("b2b_accept_busy", 32'(BUSY), 32'h1);
    chk("b2b_accept_done", 32'(DONE), 32'h0);
    wait_done(lat, bc);
    chk("b2b_latency",  32'(lat), 32'(LAT));
    chk("b2b_second_q", Q,        32'd6);
    chk("b2b_second_r", R,        32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
